// File: rtl/sib_pulse_req_queue_if.sv
// Handshake bundle between the request source and the pulse request queue.
interface sib_pulse_req_queue_if #(
    parameter int unsigned CNT_W = 4
);
    logic             req_in;
    logic             sync_rdy;
    logic             ovf_clr;
    logic             pulse_out;
    logic [CNT_W-1:0] pend_cnt;
    logic             empty;
    logic             ovf;

    modport master (
        output req_in, sync_rdy, ovf_clr,
        input  pulse_out, pend_cnt, empty, ovf
    );

    modport slave (
        input  req_in, sync_rdy, ovf_clr,
        output pulse_out, pend_cnt, empty, ovf
    );
endinterface

// File: rtl/sib_pulse_req_queue.sv
// Counts single-cycle requests and re-issues them as spaced pulses when the synchronizer is ready.
// Define SIB_PULSE_REQ_OVF_EN to enable the sticky overflow flag.
module sib_pulse_req_queue #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned HOLD_CYC = 2
) (
    input logic                   clk,
    input logic                   rst,
    sib_pulse_req_queue_if.slave  bus
);
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pulse_q;
    logic              empty_q;
    logic              dec;
    logic              drop;
    logic              inc;

    // Next-state, hold countdown and pending-count arithmetic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((cnt_q != '0) && bus.sync_rdy) begin
                    state_d = ISSUE;
                    dec     = 1'b1;
                end
            end
            ISSUE: begin
                state_d = HOLD;
                hold_d  = HOLD_W'(HOLD_CYC - 1);
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A full counter only takes a request when an issue frees a slot on the same edge.
        drop  = bus.req_in && !dec && (cnt_q == CNT_MAX);
        inc   = bus.req_in && !drop;
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            pulse_q <= (state_d == ISSUE);
            empty_q <= (cnt_d == '0);
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.pend_cnt  = cnt_q;
    assign bus.empty     = empty_q;

`ifdef SIB_PULSE_REQ_OVF_EN
    logic ovf_q;

    // Sticky flag; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_ok;

    assign unused_ok = ^{bus.ovf_clr, drop};
    assign bus.ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_sib_pulse_req_queue.sv
// Directed scoreboard bench for sib_pulse_req_queue (CNT_W=2, HOLD_CYC=2).
module tb_sib_pulse_req_queue;
    localparam int unsigned CNT_W = 2;
`ifdef SIB_PULSE_REQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic             pulse;
        logic [CNT_W-1:0] cnt;
        logic             empty;
        logic             ovf;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   cycle;
    exp_t exp_q[$];

    sib_pulse_req_queue_if #(.CNT_W(CNT_W)) bus ();

    sib_pulse_req_queue #(.CNT_W(CNT_W), .HOLD_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input bit r, input bit rq, input bit rd, input bit cl,
                        input bit chk, input bit p, input int c, input bit o);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        bus.req_in   = rq;
        bus.sync_rdy = rd;
        bus.ovf_clr  = cl;
        if (chk) begin
            e.pulse = p;
            e.cnt   = CNT_W'(c);
            e.empty = (c == 0);
            e.ovf   = o & OVF_EN;
            e.cyc   = cycle;
            exp_q.push_back(e);
        end
        cycle++;
    endtask

    // Monitor: compare DUT outputs against queued expectations mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulse_out", e.cyc, int'(bus.pulse_out), int'(e.pulse));
                check("pend_cnt",  e.cyc, int'(bus.pend_cnt),  int'(e.cnt));
                check("empty",     e.cyc, int'(bus.empty),     int'(e.empty));
                check("ovf",       e.cyc, int'(bus.ovf),       int'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; cycle = 0;
        rst = 1'b1; bus.req_in = 1'b0; bus.sync_rdy = 1'b0; bus.ovf_clr = 1'b0;

        //   rst rq rd cl chk pulse cnt ovf
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0, 0);   // request during reset is discarded
        step(0, 0, 1, 0, 1, 0, 0, 0);

        // Single request.
        step(0, 1, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);

        // Burst of three: pulses 2, 6, 10 cycles after the first request.
        step(0, 1, 1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 1, 1, 0);
        step(0, 0, 1, 0, 1, 0, 2, 0);
        step(0, 0, 1, 0, 1, 0, 2, 0);
        step(0, 0, 1, 0, 1, 0, 2, 0);
        step(0, 0, 1, 0, 1, 1, 1, 0);
        step(0, 0, 1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);

        // Ready gating: one pending request waits 20 cycles.
        step(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);

        // Saturation with sync_rdy low: five requests.
        step(0, 1, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0, 2, 0);
        step(0, 1, 0, 0, 1, 0, 3, 0);
        step(0, 1, 0, 0, 1, 0, 3, 1);
        step(0, 0, 0, 0, 1, 0, 3, 1);
        step(0, 0, 0, 1, 1, 0, 3, 1);

        // Request on the issue edge at saturation: accepted, no overflow.
        step(0, 1, 1, 0, 1, 0, 3, 0);
        // Drop during ISSUE coinciding with a clear: set wins.
        step(0, 1, 0, 1, 1, 1, 3, 0);
        step(0, 0, 0, 0, 1, 0, 3, 1);
        step(0, 0, 0, 0, 1, 0, 3, 1);
        step(0, 0, 1, 0, 1, 0, 3, 1);

        // Reset asserted in ISSUE with two pending and a request.
        step(1, 1, 1, 0, 1, 1, 2, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d expected=0 pending checks", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
